mult_div_unit: RTL

//  Iterative multiply/divide unit in the execute stage, directly downstream of the register file.

---
 rtl/mult_div_unit.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// MultDivUnit (module mult_div_unit)
//
// Iterative multiply/divide unit for the execute stage. It takes the two
// register-file read values as srcA/srcB and produces HI/LO results for
// MULT, MULTU, DIV and DIVU. The datapath is radix-2 with one iteration per
// clock:
//   - multiply: shift-add
//   - divide:   restoring division
// The latency is fixed, and the unit uses a start/busy/done handshake.
// HI/LO hold their value until the next accepted operation, so later
// move-from-HI/LO instructions can read them.
//
// Optional feature macro: MDU_HILO_WRITE_EN
//   defined   -> the hiloWe/hiloSel/hiloData port group can write HI or LO
//                directly while the unit is idle.
//   undefined -> those ports are present but ignored.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      operation request, sampled only while idle
//   op        in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   srcA      in   WIDTH  multiplicand / dividend
//   srcB      in   WIDTH  multiplier / divisor
//   hiloWe    in   1      direct HI/LO write strobe
//   hiloSel   in   1      0 = write LO, 1 = write HI
//   hiloData  in   WIDTH  direct write data
//   busy      out  1      high while an operation is running or finishing
//   done      out  1      one-cycle completion pulse
//   divZero   out  1      last operation was a divide by zero
//   hi        out  WIDTH  product upper half / remainder
//   lo        out  WIDTH  product lower half / quotient
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             hiloWe,
    input  logic             hiloSel,
    input  logic [WIDTH-1:0] hiloData,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT state;
    stateT nextState;

    logic [CW-1:0]    count;
    logic [1:0]       opReg;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] operandB;
    logic [WIDTH-1:0] dividendRaw;
    logic             negMain;
    logic             negRem;
    logic             dzPending;

    logic             accept;
    logic             lastIter;

    logic             newIsDiv;
    logic             signA;
    logic             signB;
    logic [WIDTH-1:0] magA;
    logic [WIDTH-1:0] magB;

    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic [WIDTH-1:0]   stepHi;
    logic [WIDTH-1:0]   stepLo;
    logic [2*WIDTH-1:0] prodFinal;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    // Decode an incoming request.
    // Signed ops (op[0] == 0) work on operand magnitudes. The result signs are
    // remembered separately and applied once, after the last iteration.
    assign newIsDiv = op[1];
    assign signA    = ~op[0] & srcA[WIDTH-1];
    assign signB    = ~op[0] & srcB[WIDTH-1];
    assign magA     = signA ? -srcA : srcA;
    assign magB     = signB ? -srcB : srcB;

    assign accept   = (state == IDLE) && start;
    assign lastIter = (state == BUSY) && (count == CW'(WIDTH - 1));

    // State register.
    // An asynchronous reset drops the unit back to IDLE from any state,
    // including the middle of an operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and handshake outputs.
    // DONE lasts exactly one cycle. Both BUSY and DONE report busy, so a start
    // request is only honoured from IDLE.
    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (count == CW'(WIDTH - 1)) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // One radix-2 step of the working registers.
    //
    // Multiply: accLo holds the multiplier and shifts right. Its low bit
    // decides whether the multiplicand is added into accHi. The carry out of
    // that add becomes the new top bit of the pair.
    //
    // Divide: {accHi, accLo} shifts left. The divisor is subtracted when the
    // partial remainder is large enough, and the quotient bit enters accLo
    // from the right. A set borrow bit means the trial subtraction failed, and
    // the unsubtracted value is kept.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, operandB} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divDiff  = divShift - {1'b0, operandB};
        stepHi   = mulSum[WIDTH:1];
        stepLo   = {mulSum[0], accLo[WIDTH-1:1]};
        if (opReg[1]) begin
            if (!divDiff[WIDTH]) begin
                stepHi = divDiff[WIDTH-1:0];
                stepLo = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                stepHi = divShift[WIDTH-1:0];
                stepLo = {accLo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and special cases, applied to the final step.
    //
    // Divide by zero bypasses the datapath: LO becomes all ones and HI
    // returns the original dividend.
    //
    // The signed overflow case (most negative / -1) needs no special
    // handling. Its magnitude quotient is 0x80..0, and since the quotient
    // sign is positive it is left as is.
    always_comb begin
        prodFinal = negMain ? -{stepHi, stepLo} : {stepHi, stepLo};
        resHi     = prodFinal[2*WIDTH-1:WIDTH];
        resLo     = prodFinal[WIDTH-1:0];
        if (opReg[1]) begin
            if (dzPending) begin
                resHi = dividendRaw;
                resLo = '1;
            end else begin
                resHi = negRem  ? -stepHi : stepHi;
                resLo = negMain ? -stepLo : stepLo;
            end
        end
    end

    // Working registers.
    // Operands and result signs are captured on the accept edge, so later
    // changes on srcA/srcB/op cannot disturb a running operation. Each
    // BUSY cycle then advances the datapath by one step.
    //
    // For a divide, the dividend goes in accLo and the divisor in operandB.
    // For a multiply, the multiplier goes in accLo and the multiplicand in
    // operandB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            opReg       <= '0;
            accHi       <= '0;
            accLo       <= '0;
            operandB    <= '0;
            dividendRaw <= '0;
            negMain     <= 1'b0;
            negRem      <= 1'b0;
            dzPending   <= 1'b0;
        end else if (accept) begin
            count       <= '0;
            opReg       <= op;
            accHi       <= '0;
            accLo       <= newIsDiv ? magA : magB;
            operandB    <= newIsDiv ? magB : magA;
            dividendRaw <= srcA;
            negMain     <= signA ^ signB;
            negRem      <= newIsDiv & signA;
            dzPending   <= newIsDiv && (srcB == '0);
        end else if (state == BUSY) begin
            count <= count + CW'(1);
            accHi <= stepHi;
            accLo <= stepLo;
        end
    end

    // Architectural HI/LO and the divide-by-zero flag.
    // Accepting a new operation clears divZero. Results land only on the
    // final iteration edge. When the direct-write feature is built in, an
    // idle write goes through only if no start arrives on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            divZero <= 1'b0;
        end else if (accept) begin
            divZero <= 1'b0;
        end else if (lastIter) begin
            hi      <= resHi;
            lo      <= resLo;
            divZero <= dzPending;
`ifdef MDU_HILO_WRITE_EN
        end else if ((state == IDLE) && hiloWe) begin
            if (hiloSel) begin
                hi <= hiloData;
            end else begin
                lo <= hiloData;
            end
`endif
        end
    end

`ifndef MDU_HILO_WRITE_EN
    // Without the direct-write feature, the write port group is only sunk
    // here so the interface stays identical between builds.
    logic unusedHilo;
    assign unusedHilo = ^{hiloWe, hiloSel, hiloData};
`endif

endmodule
